// File: rtl/rename_tag_pool_pkg.sv
// Shared types and default sizing for the rename-stage physical tag pool.
package rename_tag_pool_pkg;
  localparam int NUM_TAGS_DEF  = 64;
  localparam int RESERVED_DEF  = 32;
  localparam int NUM_ALLOC_DEF = 4;
  localparam int NUM_FREE_DEF  = 4;
  localparam int TAG_W_DEF     = $clog2(NUM_TAGS_DEF);

  typedef logic [TAG_W_DEF-1:0] ptag_t;

  typedef struct packed {
    logic  valid;
    ptag_t new_tag;
    ptag_t prev_tag;
  } commit_port_t;
endpackage

// File: rtl/rename_tag_pool_free_tag_finder.sv
// Returns the NUM_SLOTS lowest clear indices of a usage bitmap, lowest first,
// each with a valid flag; one tree priority encoder per slot with successive masking.
module free_tag_finder
  import rename_tag_pool_pkg::*;
#(
  parameter int NUM_TAGS  = NUM_TAGS_DEF,
  parameter int NUM_SLOTS = NUM_ALLOC_DEF,
  localparam int TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic [NUM_TAGS-1:0]             used,
  output logic [NUM_SLOTS-1:0][TAG_W-1:0] idx,
  output logic [NUM_SLOTS-1:0]            valid
);

  // Binary reduction tree: each level keeps the lower child's index when it has a hit.
  function automatic logic [TAG_W:0] first_set(input logic [NUM_TAGS-1:0] vec);
    logic [NUM_TAGS-1:0]            v;
    logic [NUM_TAGS-1:0][TAG_W-1:0] ix;
    v = vec;
    for (int n = 0; n < NUM_TAGS; n++) begin
      ix[n] = TAG_W'(n);
    end
    for (int w = NUM_TAGS / 2; w >= 1; w = w / 2) begin
      for (int n = 0; n < w; n++) begin
        ix[n] = v[2*n] ? ix[2*n] : ix[2*n+1];
        v[n]  = v[2*n] | v[2*n+1];
      end
    end
    return {v[0], ix[0]};
  endfunction

  logic [NUM_TAGS-1:0] avail_s;
  logic [TAG_W:0]      hit_s;

  // Pick successive lowest free indices, masking each pick out for the next slot.
  always_comb begin
    avail_s = ~used;
    hit_s   = '0;
    idx     = '0;
    valid   = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      hit_s    = first_set(avail_s);
      valid[k] = hit_s[TAG_W];
      idx[k]   = hit_s[TAG_W-1:0];
      if (hit_s[TAG_W]) begin
        avail_s[hit_s[TAG_W-1:0]] = 1'b0;
      end else begin
        avail_s = avail_s;
      end
    end
  end

endmodule

// File: rtl/rename_tag_pool.sv
// Physical tag free pool: in-order prefix allocation, commit-time freeing,
// and a committed shadow bitmap for single-cycle mispredict recovery.
module rename_tag_pool
  import rename_tag_pool_pkg::*;
#(
  parameter int NUM_TAGS  = NUM_TAGS_DEF,
  parameter int RESERVED  = RESERVED_DEF,
  parameter int NUM_ALLOC = NUM_ALLOC_DEF,
  parameter int NUM_FREE  = NUM_FREE_DEF,
  localparam int TAG_W    = $clog2(NUM_TAGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_ALLOC-1:0]       IN_allocReq,
  output logic [NUM_ALLOC-1:0]       OUT_allocGrant,
  output logic [NUM_ALLOC*TAG_W-1:0] OUT_allocTag,
  input  logic [NUM_FREE-1:0]        IN_commitValid,
  input  logic [NUM_FREE*TAG_W-1:0]  IN_commitNewTag,
  input  logic [NUM_FREE*TAG_W-1:0]  IN_commitPrevTag,
  input  logic                       IN_mispr,
  output logic [TAG_W:0]             OUT_freeCount,
  output logic                       OUT_err
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] new_tag;
    logic [TAG_W-1:0] prev_tag;
  } cport_t;

  localparam logic [NUM_TAGS-1:0] RESET_MAP  = {{(NUM_TAGS-RESERVED){1'b0}}, {RESERVED{1'b1}}};
  localparam logic [TAG_W:0]      RESET_FREE = (TAG_W+1)'(NUM_TAGS - RESERVED);

  logic [NUM_TAGS-1:0]             spec_used_r;
  logic [NUM_TAGS-1:0]             com_used_r;
  logic [NUM_TAGS-1:0]             spec_next_s;
  logic [NUM_TAGS-1:0]             com_next_s;
  logic [TAG_W:0]                  free_count_r;
  logic [TAG_W:0]                  free_count_next_s;
  logic                            err_r;
  logic                            err_hit_s;
  logic [NUM_ALLOC-1:0][TAG_W-1:0] find_idx_s;
  logic [NUM_ALLOC-1:0]            find_valid_s;
  logic [NUM_ALLOC-1:0]            grant_s;
  logic [NUM_ALLOC-1:0][TAG_W-1:0] tag_s;
  cport_t [NUM_FREE-1:0]           cport_s;

  free_tag_finder #(
    .NUM_TAGS  (NUM_TAGS),
    .NUM_SLOTS (NUM_ALLOC)
  ) u_finder (
    .used  (spec_used_r),
    .idx   (find_idx_s),
    .valid (find_valid_s)
  );

  // The n-th requesting port takes the n-th free tag; once free tags run out,
  // every later requester also fails, which yields the in-order prefix.
  always_comb begin : grant_logic
    int cum;
    logic             sel_valid;
    logic [TAG_W-1:0] sel_idx;
    cum       = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    grant_s   = '0;
    tag_s     = '0;
    for (int i = 0; i < NUM_ALLOC; i++) begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < NUM_ALLOC; k++) begin
        if (cum == k) begin
          sel_valid = find_valid_s[k];
          sel_idx   = find_idx_s[k];
        end else begin
          sel_valid = sel_valid;
        end
      end
      if (IN_allocReq[i]) begin
        if (rst_n && !IN_mispr && sel_valid) begin
          grant_s[i] = 1'b1;
          tag_s[i]   = sel_idx;
        end else begin
          grant_s[i] = 1'b0;
        end
        cum = cum + 1;
      end else begin
        grant_s[i] = 1'b0;
      end
    end
  end

  assign OUT_allocGrant = grant_s;
  assign OUT_allocTag   = tag_s;

  // Unpack the flat commit buses into per-port records.
  always_comb begin
    cport_s = '0;
    for (int p = 0; p < NUM_FREE; p++) begin
      cport_s[p].valid    = IN_commitValid[p];
      cport_s[p].new_tag  = IN_commitNewTag[p*TAG_W +: TAG_W];
      cport_s[p].prev_tag = IN_commitPrevTag[p*TAG_W +: TAG_W];
    end
  end

  // Commits are checked and applied on running copies in port order, so a later
  // port sees (and may clear) an earlier port's new tag; allocations follow.
  always_comb begin
    spec_next_s = spec_used_r;
    com_next_s  = com_used_r;
    err_hit_s   = 1'b0;
    for (int p = 0; p < NUM_FREE; p++) begin
      if (cport_s[p].valid) begin
        if (!spec_next_s[cport_s[p].new_tag] || !com_next_s[cport_s[p].prev_tag] ||
            (cport_s[p].new_tag == cport_s[p].prev_tag)) begin
          err_hit_s = 1'b1;
        end else begin
          err_hit_s = err_hit_s;
        end
        com_next_s[cport_s[p].new_tag]   = 1'b1;
        com_next_s[cport_s[p].prev_tag]  = 1'b0;
        spec_next_s[cport_s[p].prev_tag] = 1'b0;
      end else begin
        err_hit_s = err_hit_s;
      end
    end
    for (int i = 0; i < NUM_ALLOC; i++) begin
      if (grant_s[i]) begin
        spec_next_s[tag_s[i]] = 1'b1;
      end else begin
        spec_next_s = spec_next_s;
      end
    end
    if (IN_mispr) begin
      spec_next_s = com_next_s;
    end else begin
      spec_next_s = spec_next_s;
    end
  end

  // Free count of the state about to be registered.
  always_comb begin
    free_count_next_s = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      free_count_next_s = free_count_next_s + {{TAG_W{1'b0}}, ~spec_next_s[t]};
    end
  end

  // Pool state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_used_r  <= RESET_MAP;
      com_used_r   <= RESET_MAP;
      free_count_r <= RESET_FREE;
      err_r        <= 1'b0;
    end else begin
      spec_used_r  <= spec_next_s;
      com_used_r   <= com_next_s;
      free_count_r <= free_count_next_s;
      err_r        <= err_r | err_hit_s;
    end
  end

  assign OUT_freeCount = free_count_r;
  assign OUT_err       = err_r;

endmodule

// File: tb/tb_rename_tag_pool.sv
// Self-checking bench for rename_tag_pool: directed scenarios plus a randomized
// rename/commit/flush stream checked against a bitmap model every cycle.
`timescale 1ns/1ps
module tb_rename_tag_pool;
  import rename_tag_pool_pkg::*;

  localparam int NT = NUM_TAGS_DEF;
  localparam int RS = RESERVED_DEF;
  localparam int NA = NUM_ALLOC_DEF;
  localparam int NF = NUM_FREE_DEF;
  localparam int TW = TAG_W_DEF;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [NA-1:0]   req = '0;
  logic [NA-1:0]   grant;
  logic [NA*TW-1:0] tags;
  logic [NF-1:0]   cvalid = '0;
  logic [NF*TW-1:0] cnew = '0;
  logic [NF*TW-1:0] cprev = '0;
  logic            mispr = 1'b0;
  logic [TW:0]     fcount;
  logic            err;

  always #5 clk = ~clk;

  rename_tag_pool dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IN_allocReq      (req),
    .OUT_allocGrant   (grant),
    .OUT_allocTag     (tags),
    .IN_commitValid   (cvalid),
    .IN_commitNewTag  (cnew),
    .IN_commitPrevTag (cprev),
    .IN_mispr         (mispr),
    .OUT_freeCount    (fcount),
    .OUT_err          (err)
  );

  int n_pass = 0;
  int n_total = 0;

  bit spec_m[NT];
  bit com_m[NT];
  bit err_m;
  logic [NA-1:0] exp_grant;
  int exp_tag[NA];
  commit_port_t cp[NF];
  logic [NA-1:0] dut_grant_q;
  int dut_tag_q[NA];

  typedef struct { int r; int tag; int prev; } pend_t;
  pend_t pend[$];
  int spec_rat[32];
  int com_rat[32];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int model_free();
    int c = 0;
    for (int t = 0; t < NT; t++) if (!spec_m[t]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      spec_m[t] = (t < RS);
      com_m[t]  = (t < RS);
    end
    err_m = 1'b0;
  endtask

  task automatic clear_cp();
    for (int p = 0; p < NF; p++) cp[p] = '0;
  endtask

  task automatic drive_commits();
    for (int p = 0; p < NF; p++) begin
      cvalid[p]          = cp[p].valid;
      cnew[p*TW +: TW]   = cp[p].new_tag;
      cprev[p*TW +: TW]  = cp[p].prev_tag;
    end
  endtask

  // Requesters in order take entries from the ascending free list until it runs out.
  task automatic model_comb();
    int freeq[$];
    int n = 0;
    for (int t = 0; t < NT; t++) if (!spec_m[t]) freeq.push_back(t);
    exp_grant = '0;
    for (int i = 0; i < NA; i++) exp_tag[i] = 0;
    if (!mispr) begin
      for (int i = 0; i < NA; i++) begin
        if (req[i] && n < freeq.size()) begin
          exp_grant[i] = 1'b1;
          exp_tag[i]   = freeq[n];
          n++;
        end
      end
    end
  endtask

  task automatic model_edge();
    for (int p = 0; p < NF; p++) begin
      if (cp[p].valid) begin
        int nt = int'(cp[p].new_tag);
        int pt = int'(cp[p].prev_tag);
        if (!spec_m[nt] || !com_m[pt] || nt == pt) err_m = 1'b1;
        com_m[nt]  = 1'b1;
        com_m[pt]  = 1'b0;
        spec_m[pt] = 1'b0;
      end
    end
    for (int i = 0; i < NA; i++) if (exp_grant[i]) spec_m[exp_tag[i]] = 1'b1;
    if (mispr) spec_m = com_m;
  endtask

  // One clock: compare combinational grants mid-cycle, then registered outputs after the edge.
  task automatic step();
    drive_commits();
    #3;
    model_comb();
    dut_grant_q = grant;
    for (int i = 0; i < NA; i++) dut_tag_q[i] = int'(tags[i*TW +: TW]);
    chk("grant", grant, exp_grant);
    for (int i = 0; i < NA; i++) if (exp_grant[i]) chk("tag", dut_tag_q[i], exp_tag[i]);
    @(posedge clk);
    model_edge();
    #1;
    chk("free_count", fcount, model_free());
    chk("err", err, err_m);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_free_count", fcount, NT - RS);
    chk("rst_err", err, 0);
    req = '0;
    mispr = 1'b0;
    clear_cp();
    drive_commits();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [NA-1:0] r, input logic m);
    req = r;
    mispr = m;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_cp();
    model_reset();
    req = 4'b1111;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_free_count", fcount, NT - RS);
    chk("rst_err", err, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full allocation from reset
    set_in(4'b1111, 1'b0); step();
    chk("t1_grant", dut_grant_q, 4'b1111);
    chk("t1_tag0", dut_tag_q[0], 32);
    chk("t1_tag1", dut_tag_q[1], 33);
    chk("t1_tag2", dut_tag_q[2], 34);
    chk("t1_tag3", dut_tag_q[3], 35);
    chk("t1_free", fcount, 28);

    // Commit frees tag 5, not reusable in the same cycle
    cp[0] = '{1'b1, 6'd32, 6'd5};
    set_in(4'b0001, 1'b0); step();
    chk("t3_same_cycle_tag", dut_tag_q[0], 36);
    chk("t3_free", fcount, 28);
    clear_cp(); step();
    chk("t3_tag5", dut_tag_q[0], 5);
    chk("t3_free2", fcount, 27);

    // Same-register chain inside one commit group
    set_in(4'b1111, 1'b0); step();
    chk("t4_tag40", dut_tag_q[3], 40);
    set_in(4'b0001, 1'b0); step();
    chk("t4_tag41", dut_tag_q[0], 41);
    cp[0] = '{1'b1, 6'd40, 6'd7};
    cp[1] = '{1'b1, 6'd41, 6'd40};
    set_in(4'b0000, 1'b0); step();
    chk("t4_free", fcount, 24);
    chk("t4_err", err, 0);
    clear_cp();
    set_in(4'b0011, 1'b0); step();
    chk("t4_tag7", dut_tag_q[0], 7);
    chk("t4_tag40b", dut_tag_q[1], 40);

    // Mispredict restores the committed shadow
    cp[0] = '{1'b1, 6'd33, 6'd6};
    set_in(4'b0000, 1'b0); step();
    clear_cp();
    set_in(4'b1111, 1'b1); step();
    chk("t5_mispr_grant", dut_grant_q, 4'b0000);
    chk("t5_free", fcount, 32);
    set_in(4'b1111, 1'b0); step();
    chk("t5_tag0", dut_tag_q[0], 5);
    chk("t5_tag1", dut_tag_q[1], 6);
    chk("t5_tag2", dut_tag_q[2], 7);
    chk("t5_tag3", dut_tag_q[3], 34);

    // Drain to two free, then partial and empty-pool grants
    repeat (6) step();
    set_in(4'b0011, 1'b0); step();
    chk("t2_free2", fcount, 2);
    set_in(4'b1111, 1'b0); step();
    chk("t2_partial", dut_grant_q, 4'b0011);
    chk("t2_free0", fcount, 0);
    set_in(4'b1101, 1'b0); step();
    chk("t2_empty", dut_grant_q, 4'b0000);
    chk("t2_free0b", fcount, 0);

    do_reset();

    // Randomized rename/commit/flush stream driven from a RAT model
    for (int r = 0; r < 32; r++) begin
      spec_rat[r] = r;
      com_rat[r]  = r;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int ncm;
      req   = NA'($urandom);
      mispr = ($urandom_range(0, 99) < 3);
      ncm   = $urandom_range(0, ((cyc % 400) < 200) ? 1 : 4);
      if (ncm > pend.size()) ncm = pend.size();
      clear_cp();
      for (int p = 0; p < ncm; p++) begin
        cp[p].valid    = 1'b1;
        cp[p].new_tag  = ptag_t'(pend[p].tag);
        cp[p].prev_tag = ptag_t'(pend[p].prev);
      end
      step();
      for (int p = 0; p < ncm; p++) begin
        com_rat[pend[0].r] = pend[0].tag;
        void'(pend.pop_front());
      end
      if (mispr) begin
        pend.delete();
        spec_rat = com_rat;
      end else begin
        for (int i = 0; i < NA; i++) begin
          if (exp_grant[i]) begin
            int r = $urandom_range(1, 31);
            pend.push_back('{r, exp_tag[i], spec_rat[r]});
            spec_rat[r] = exp_tag[i];
          end
        end
      end
    end
    clear_cp();
    set_in(4'b0000, 1'b0);

    // Error: prev tag not committed; sticky until reset mid-burst
    do_reset();
    set_in(4'b0001, 1'b0); step();
    cp[0] = '{1'b1, 6'd32, 6'd40};
    set_in(4'b0000, 1'b0); step();
    chk("e1_err", err, 1);
    clear_cp();
    set_in(4'b1111, 1'b0);
    repeat (3) step();
    chk("e1_sticky", err, 1);
    do_reset();

    // Error: prev equals new on one port
    cp[0] = '{1'b1, 6'd5, 6'd5};
    step();
    chk("e2_err", err, 1);
    clear_cp();
    do_reset();

    // Error: new tag never allocated
    cp[0] = '{1'b1, 6'd50, 6'd3};
    step();
    chk("e3_err", err, 1);
    clear_cp();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
